// File: rtl/rlwe_coeffwise_sequencer.sv
// Coefficient-wise add/sub/mul sequencer: walks a LEN-entry address window, issues reads every II
// cycles, writes after a mode-dependent latency. Optional freeze input enabled by RLWE_SEQ_HOLD_EN.
module rlwe_coeffwise_sequencer #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned LEN        = 1024,
    parameter int unsigned CORE_INDEX = 0,
    parameter int unsigned II         = 2,
    parameter int unsigned ADD_LAT    = 7,
    parameter int unsigned MUL_LAT    = 14
) (
    input  logic              clk,
    input  logic              rst,        // active-low, asynchronous
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wea,
    output logic [1:0]        addin_sel,
    output logic              sub,
    output logic [1:0]        wtsel1
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(CORE_INDEX * LEN);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LEN - 1);

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpMul = 2'b10;
    localparam logic [1:0] OpBad = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic [ADDR_W-1:0]   m_q, m_d;
    logic                phase_q, phase_d;
    logic [MUL_LAT-1:0]  vld_q, vld_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic freeze;
    logic rd_fire;
    logic tap;
    logic wr_fire;

`ifdef RLWE_SEQ_HOLD_EN
    assign freeze = hold && (state_q != StIdle);
`else
    logic unused_hold;
    assign unused_hold = hold;
    assign freeze      = 1'b0;
`endif

    assign rd_fire = (state_q == StIssue) && !phase_q && !freeze;
    assign tap     = (op_q == OpMul) ? vld_q[MUL_LAT-1] : vld_q[ADD_LAT-1];
    assign wr_fire = tap && !freeze;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        k_d     = k_q;
        m_d     = m_q;
        phase_d = phase_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (!freeze) begin
            vld_d = (vld_q << 1) | MUL_LAT'(rd_fire);
            if (wr_fire) begin
                m_d = (m_q == LAST) ? '0 : m_q + ADDR_W'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (op == OpBad) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = StIssue;
                            op_d    = op;
                            k_d     = '0;
                            m_d     = '0;
                            phase_d = 1'b0;
                            // Bits beyond the add tap may still be in flight from a previous op.
                            vld_d   = '0;
                        end
                    end
                end
                StIssue: begin
                    if (II > 1) begin
                        phase_d = ~phase_q;
                    end
                    if (rd_fire) begin
                        if (k_q == LAST) begin
                            k_d     = '0;
                            state_d = StDrain;
                        end else begin
                            k_d = k_q + ADDR_W'(1);
                        end
                    end
                end
                StDrain: begin
                    if (wr_fire && (m_q == LAST)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            op_q    <= OpAdd;
            k_q     <= '0;
            m_q     <= '0;
            phase_q <= 1'b0;
            vld_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            k_q     <= k_d;
            m_q     <= m_d;
            phase_q <= phase_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign err       = err_q;
    assign rd_en     = rd_fire;
    assign wea       = wr_fire;
    assign rd_addr   = BASE + k_q;
    assign wr_addr   = BASE + m_q;
    assign addin_sel = (op_q == OpMul) ? 2'd2 : 2'd1;
    assign sub       = (op_q == OpSub);
    assign wtsel1    = (op_q == OpMul) ? 2'd1 : 2'd3;

endmodule

// File: tb/tb_rlwe_coeffwise_sequencer.sv
// Bench for rlwe_coeffwise_sequencer: a small window instance (LEN=4, II=2) and a core-1 instance
// (LEN=1024, II=1), checked against a queue-based read/write/done schedule.
module tb_rlwe_coeffwise_sequencer;

    localparam int AW  = 11;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start_s[2];
    logic          hold_s[2];
    logic [1:0]    op_s[2];
    logic          busy_w[2], done_w[2], err_w[2], rd_en_w[2], wea_w[2], sub_w[2];
    logic [AW-1:0] rd_addr_w[2], wr_addr_w[2];
    logic [1:0]    asel_w[2], wts_w[2];

    int base_of[2];

    rlwe_coeffwise_sequencer #(
        .ADDR_W(AW), .LEN(4), .CORE_INDEX(0), .II(2), .ADD_LAT(7), .MUL_LAT(14)
    ) u_a (
        .clk(clk), .rst(rst), .start(start_s[0]), .op(op_s[0]), .hold(hold_s[0]),
        .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]), .rd_addr(rd_addr_w[0]),
        .rd_en(rd_en_w[0]), .wr_addr(wr_addr_w[0]), .wea(wea_w[0]), .addin_sel(asel_w[0]),
        .sub(sub_w[0]), .wtsel1(wts_w[0])
    );

    rlwe_coeffwise_sequencer #(
        .ADDR_W(AW), .LEN(1024), .CORE_INDEX(1), .II(1), .ADD_LAT(7), .MUL_LAT(14)
    ) u_b (
        .clk(clk), .rst(rst), .start(start_s[1]), .op(op_s[1]), .hold(hold_s[1]),
        .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]), .rd_addr(rd_addr_w[1]),
        .rd_en(rd_en_w[1]), .wr_addr(wr_addr_w[1]), .wea(wea_w[1]), .addin_sel(asel_w[1]),
        .sub(sub_w[1]), .wtsel1(wts_w[1])
    );

    typedef struct {
        int         cyc;
        int         addr;
        logic [1:0] asel;
        logic       sb;
        logic [1:0] wts;
    } ev_t;

    typedef struct {
        logic [1:0] op;
        int         lat;
        logic [1:0] asel;
        logic       sb;
        logic [1:0] wts;
    } vec_t;

    ev_t rdq[2][$];
    ev_t wrq[2][$];
    int  dnq[2][$];
    int  erq[2][$];

    int errs = 0;
    int nchk = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bad(input string nm, input int i);
        nchk++;
        errs++;
        $display("FAIL %s inst%0d: got pulse/timeout, want none (cycle %0d)", nm, i, cyc);
    endtask

    // Event monitor: every DUT pulse must match the head of its expectation queue.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en_w[i] === 1'b1) begin
                if (rdq[i].size() == 0) bad("rd_en_unexpected", i);
                else begin
                    ev_t e;
                    e = rdq[i].pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_addr", int'(rd_addr_w[i]), e.addr);
                    chk("addin_sel", int'(asel_w[i]), int'(e.asel));
                    chk("sub", int'(sub_w[i]), int'(e.sb));
                    chk("wtsel1", int'(wts_w[i]), int'(e.wts));
                    chk("busy_on_read", int'(busy_w[i]), 1);
                end
            end
            if (wea_w[i] === 1'b1) begin
                if (wrq[i].size() == 0) bad("wea_unexpected", i);
                else begin
                    ev_t e;
                    e = wrq[i].pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_addr", int'(wr_addr_w[i]), e.addr);
                    chk("busy_on_write", int'(busy_w[i]), 1);
                end
            end
            if (done_w[i] === 1'b1) begin
                if (dnq[i].size() == 0) bad("done_unexpected", i);
                else begin
                    int c;
                    c = dnq[i].pop_front();
                    chk("done_cycle", cyc, c);
                    chk("busy_at_done", int'(busy_w[i]), 0);
                    chk("rd_addr_at_done", int'(rd_addr_w[i]), base_of[i]);
                    chk("wr_addr_at_done", int'(wr_addr_w[i]), base_of[i]);
                end
            end
            if (err_w[i] === 1'b1) begin
                if (erq[i].size() == 0) bad("err_unexpected", i);
                else begin
                    int c;
                    c = erq[i].pop_front();
                    chk("err_cycle", cyc, c);
                    chk("busy_at_err", int'(busy_w[i]), 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input int i);
        rdq[i].delete();
        wrq[i].delete();
        dnq[i].delete();
        erq[i].delete();
    endtask

    // Expected schedule; events at or after hold start hs slip by hl cycles.
    task automatic sched(input int i, input vec_t v, input int t0, input int len, input int ii,
                         input int hs, input int hl);
        ev_t e;
        int  c;
        e.asel = v.asel;
        e.sb   = v.sb;
        e.wts  = v.wts;
        for (int k = 0; k < len; k++) begin
            c = 1 + ii * k;
            if (c >= hs) c += hl;
            e.cyc  = t0 + c;
            e.addr = base_of[i] + k;
            rdq[i].push_back(e);
            c = 1 + ii * k + v.lat;
            if (c >= hs) c += hl;
            e.cyc = t0 + c;
            wrq[i].push_back(e);
        end
        c = 2 + ii * (len - 1) + v.lat;
        if (c >= hs) c += hl;
        dnq[i].push_back(t0 + c);
    endtask

    task automatic pulse_start(input int i, input logic [1:0] o, output int t0);
        start_s[i] = 1'b1;
        op_s[i]    = o;
        t0         = cyc;
        tick();
        start_s[i] = 1'b0;
        op_s[i]    = 2'b00;
    endtask

    task automatic drain(input int i);
        int n = 0;
        while ((rdq[i].size() + wrq[i].size() + dnq[i].size() + erq[i].size()) != 0
               && n < 4000) begin
            tick();
            n++;
        end
        if (n >= 4000) begin
            bad("drain_timeout", i);
            flush(i);
        end
        repeat (3) tick();
    endtask

    task automatic chk_rst(input int i);
        chk("rst_busy", int'(busy_w[i]), 0);
        chk("rst_done", int'(done_w[i]), 0);
        chk("rst_err", int'(err_w[i]), 0);
        chk("rst_rd_en", int'(rd_en_w[i]), 0);
        chk("rst_wea", int'(wea_w[i]), 0);
        chk("rst_sub", int'(sub_w[i]), 0);
        chk("rst_addin_sel", int'(asel_w[i]), 1);
        chk("rst_wtsel1", int'(wts_w[i]), 3);
        chk("rst_rd_addr", int'(rd_addr_w[i]), base_of[i]);
        chk("rst_wr_addr", int'(wr_addr_w[i]), base_of[i]);
    endtask

    function automatic vec_t mk(input logic [1:0] o, input int lat, input logic [1:0] a,
                                input logic s, input logic [1:0] w);
        vec_t v;
        v.op   = o;
        v.lat  = lat;
        v.asel = a;
        v.sb   = s;
        v.wts  = w;
        return v;
    endfunction

    initial begin
        vec_t tbl[3];
        int   t0;
        int   t1;
        int   hl;

        tbl[0] = mk(2'b00, 7, 2'd1, 1'b0, 2'd3);
        tbl[1] = mk(2'b01, 7, 2'd1, 1'b1, 2'd3);
        tbl[2] = mk(2'b10, 14, 2'd2, 1'b0, 2'd1);
        base_of[0] = 0;
        base_of[1] = 1024;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            hold_s[i]  = 1'b0;
            op_s[i]    = 2'b00;
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        tick();
        chk_rst(0);
        chk_rst(1);

        // Each op kind on the small window.
        for (int j = 0; j < 3; j++) begin
            pulse_start(0, tbl[j].op, t0);
            sched(0, tbl[j], t0, 4, 2, BIG, 0);
            drain(0);
        end

        // Add followed by a mul started on the add's done cycle.
        pulse_start(0, 2'b00, t0);
        sched(0, tbl[0], t0, 4, 2, BIG, 0);
        while (cyc < t0 + 15) tick();
        pulse_start(0, 2'b10, t1);
        sched(0, tbl[2], t1, 4, 2, BIG, 0);
        drain(0);

        // Illegal op: one err pulse, never busy.
        pulse_start(0, 2'b11, t0);
        erq[0].push_back(t0 + 1);
        tick();
        chk("illegal_busy", int'(busy_w[0]), 0);
        chk("err_one_cycle", int'(err_w[0]), 0);
        drain(0);

        // Starts while busy (illegal and legal op) are ignored.
        pulse_start(0, 2'b00, t0);
        sched(0, tbl[0], t0, 4, 2, BIG, 0);
        while (cyc < t0 + 4) tick();
        pulse_start(0, 2'b11, t1);
        tick();
        pulse_start(0, 2'b10, t1);
        drain(0);

        // Hold for three cycles mid-issue.
`ifdef RLWE_SEQ_HOLD_EN
        hl = 3;
`else
        hl = 0;
`endif
        pulse_start(0, 2'b00, t0);
        sched(0, tbl[0], t0, 4, 2, 4, hl);
        while (cyc < t0 + 4) tick();
        hold_s[0] = 1'b1;
        repeat (3) tick();
        hold_s[0] = 1'b0;
        drain(0);

        // Reset in the middle of a mul; nothing may follow, then a clean add.
        pulse_start(0, 2'b10, t0);
        sched(0, tbl[2], t0, 4, 2, BIG, 0);
        while (cyc < t0 + 5) tick();
        rst = 1'b0;
        #1;
        chk_rst(0);
        chk_rst(1);
        flush(0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (20) tick();
        pulse_start(0, 2'b00, t0);
        sched(0, tbl[0], t0, 4, 2, BIG, 0);
        drain(0);

        // Core 1, full length, II=1, sub.
        pulse_start(1, 2'b01, t0);
        sched(1, tbl[1], t0, 1024, 1, BIG, 0);
        drain(1);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
